// File: rtl/tile_scan_seq.sv
// Raster sequencer driving a triangle tile's nop/restart/stepy/stepx command and
// streaming one pixel per handshake. Optional macro TILESEQ_BACK2BACK_EN chains frames from FINISH.
module tile_scan_seq #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic          busy,
  output logic          done,
  output logic [1:0]    command,
  input  logic          inside_triangle,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_hit,
  output logic          pix_last
);

  typedef enum logic [2:0] {S_IDLE, S_RESTART, S_SCAN, S_STEPY, S_FINISH} state_t;
  typedef enum logic [1:0] {CMD_NOP, CMD_RESTART, CMD_STEPY, CMD_STEPX} cmd_t;

  state_t        r_state, w_next;
  cmd_t          w_cmd;
  logic [XW-1:0] r_x, r_w;
  logic [YW-1:0] r_y, r_h;
  logic          w_dims_ok, w_take, w_hs, w_x_end, w_y_end;

  assign w_dims_ok = (|width) && (|height);
`ifdef TILESEQ_BACK2BACK_EN
  assign w_take = start && (r_state == S_IDLE || r_state == S_FINISH);
`else
  assign w_take = start && (r_state == S_IDLE);
`endif
  assign w_hs    = (r_state == S_SCAN) && pix_ready;
  assign w_x_end = (r_x == r_w - XW'(1));
  assign w_y_end = (r_y == r_h - YW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_take) w_next = w_dims_ok ? S_RESTART : S_FINISH;
      S_RESTART: w_next = S_SCAN;
      S_SCAN:    if (w_hs && w_x_end) w_next = w_y_end ? S_FINISH : S_STEPY;
      S_STEPY:   w_next = S_SCAN;
      S_FINISH:  w_next = w_take ? (w_dims_ok ? S_RESTART : S_FINISH) : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Dimensions are only captured for a frame that will actually be walked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_w <= '0;
      r_h <= '0;
    end else begin
      if (w_take && w_dims_ok) begin
        r_w <= width;
        r_h <= height;
      end
      case (r_state)
        S_RESTART: begin
          r_x <= '0;
          r_y <= '0;
        end
        S_SCAN: if (w_hs && !w_x_end) r_x <= r_x + XW'(1);
        S_STEPY: begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cmd     = CMD_NOP;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FINISH);
    pix_valid = (r_state == S_SCAN);
    case (r_state)
      S_RESTART: w_cmd = CMD_RESTART;
      S_SCAN:    w_cmd = pix_ready ? CMD_STEPX : CMD_NOP;
      S_STEPY:   w_cmd = CMD_STEPY;
      default:   w_cmd = CMD_NOP;
    endcase
  end

  assign command  = w_cmd;
  assign pix_x    = r_x;
  assign pix_y    = r_y;
  assign pix_hit  = inside_triangle;
  assign pix_last = pix_valid && w_x_end && w_y_end;

endmodule

// File: tb/tb_tile_scan_seq.sv
// Directed bench for tile_scan_seq with a small tile model that tracks commands
// and answers inside_triangle from a reference edge function.
module tb_tile_scan_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] width = '0;
  logic [9:0] height = '0;
  logic       busy, done, pix_valid, pix_hit, pix_last;
  logic [1:0] command;
  logic       inside_triangle;
  logic       pix_ready = 1'b0;
  logic [9:0] pix_x, pix_y;

  logic use_model = 1'b1;
  logic tb_hit = 1'b0;
  logic model_hit;
  int   tx = 0, ty = 0, n1 = 0, n2 = 0, n3 = 0;
  int   n_chk = 0, n_pass = 0;

  tile_scan_seq #(.XW(10), .YW(10)) dut (
    .clock(clock), .reset(reset), .start(start), .width(width), .height(height),
    .busy(busy), .done(done), .command(command), .inside_triangle(inside_triangle),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_hit(pix_hit), .pix_last(pix_last)
  );

  always #5 clock = ~clock;

  function automatic logic edge_in(input int x, input int y);
    return (2 * y - x + 1) >= 0;
  endfunction

  // Tile model: edge accumulator position advanced by the sequencer's commands.
  always @(posedge clock) begin
    case (command)
      2'd1: begin tx <= 0; ty <= 0; n1 <= n1 + 1; end
      2'd2: begin tx <= 0; ty <= ty + 1; n2 <= n2 + 1; end
      2'd3: begin tx <= tx + 1; n3 <= n3 + 1; end
      default: ;
    endcase
  end

  assign model_hit       = edge_in(tx, ty);
  assign inside_triangle = use_model ? model_hit : tb_hit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input bit stall, input int abort_idx);
    int idx, s1, s2, s3;
    s1 = n1; s2 = n2; s3 = n3;
    width = 10'(w); height = 10'(h); start = 1'b1; pix_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_cmd", 32'(command), 1);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_valid", 32'(pix_valid), 0);
    tick();
    idx = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (stall) begin
          pix_ready = 1'b0; #1;
          chk("stall_valid", 32'(pix_valid), 1);
          chk("stall_cmd", 32'(command), 0);
          chk("stall_x", 32'(pix_x), 32'(x));
          chk("stall_y", 32'(pix_y), 32'(y));
          chk("stall_hit", 32'(pix_hit), 32'(edge_in(x, y)));
          tick();
        end
        pix_ready = 1'b1; #1;
        if (idx == abort_idx) begin
          reset = 1'b1; #1;
          chk("rst_cmd", 32'(command), 0);
          chk("rst_valid", 32'(pix_valid), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_done", 32'(done), 0);
          chk("rst_x", 32'(pix_x), 0);
          chk("rst_y", 32'(pix_y), 0);
          return;
        end
        chk("pix_valid", 32'(pix_valid), 1);
        chk("pix_cmd", 32'(command), 3);
        chk("pix_x", 32'(pix_x), 32'(x));
        chk("pix_y", 32'(pix_y), 32'(y));
        chk("pix_hit", 32'(pix_hit), 32'(edge_in(x, y)));
        chk("pix_last", 32'(pix_last), 32'((x == w - 1) && (y == h - 1)));
        tick();
        idx++;
      end
      if (y < h - 1) begin
        chk("stepy_cmd", 32'(command), 2);
        chk("stepy_valid", 32'(pix_valid), 0);
        chk("stepy_busy", 32'(busy), 1);
        tick();
      end
    end
    chk("finish_done", 32'(done), 1);
    chk("finish_cmd", 32'(command), 0);
    chk("finish_busy", 32'(busy), 1);
    chk("finish_valid", 32'(pix_valid), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("n_restart", 32'(n1 - s1), 1);
    chk("n_stepy", 32'(n2 - s2), 32'(h - 1));
    chk("n_stepx", 32'(n3 - s3), 32'(w * h));
  endtask

  initial begin
    #2 reset = 1'b1;
    use_model = 1'b0;
    tb_hit = 1'b1;
    #1;
    chk("reset_cmd", 32'(command), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_valid", 32'(pix_valid), 0);
    chk("reset_last", 32'(pix_last), 0);
    chk("reset_x", 32'(pix_x), 0);
    chk("reset_y", 32'(pix_y), 0);
    chk("reset_hit1", 32'(pix_hit), 1);
    tb_hit = 1'b0; #1;
    chk("reset_hit0", 32'(pix_hit), 0);
    tick();
    reset = 1'b0;
    use_model = 1'b1;
    tick();

    run_frame(3, 2, 1'b0, -1);
    run_frame(3, 2, 1'b1, -1);
    run_frame(4, 3, 1'b0, -1);

    // Zero width: straight to FINISH, no pixels, no tile restart.
    begin
      int s1;
      s1 = n1;
      width = 10'd0; height = 10'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", 32'(done), 1);
      chk("zero_valid", 32'(pix_valid), 0);
      chk("zero_cmd", 32'(command), 0);
      tick();
      chk("zero_idle_done", 32'(done), 0);
      chk("zero_idle_busy", 32'(busy), 0);
      chk("zero_no_restart", 32'(n1 - s1), 0);
    end

    // Reset lands at pixel (1,1) of a 3x2 frame, then a clean frame follows.
    run_frame(3, 2, 1'b0, 4);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    run_frame(3, 2, 1'b0, -1);

    // Start held high through FINISH on a 1x1 frame.
    width = 10'd1; height = 10'd1; start = 1'b1; pix_ready = 1'b1;
    tick();
    chk("b2b_restart", 32'(command), 1);
    tick();
    chk("b2b_scan_cmd", 32'(command), 3);
    chk("b2b_scan_last", 32'(pix_last), 1);
    tick();
    chk("b2b_done", 32'(done), 1);
    tick();
`ifdef TILESEQ_BACK2BACK_EN
    chk("b2b_next_cmd", 32'(command), 1);
    chk("b2b_next_busy", 32'(busy), 1);
    start = 1'b0;
`else
    chk("b2b_idle_cmd", 32'(command), 0);
    chk("b2b_idle_busy", 32'(busy), 0);
    tick();
    chk("b2b_next_cmd", 32'(command), 1);
    start = 1'b0;
`endif
    tick();
    chk("b2b2_scan_cmd", 32'(command), 3);
    chk("b2b2_scan_x", 32'(pix_x), 0);
    tick();
    chk("b2b2_done", 32'(done), 1);
    tick();
    chk("b2b2_idle_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
